// File: rtl/preamble_tx_pkg.sv
// Shared types and constants for the preamble serializer: FSM state encoding
// and the fixed 4-bit preamble sent ahead of every payload.
package preamble_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_PARITY,
    ST_DONE
  } state_t;

  localparam logic [3:0] PREAMBLE     = 4'b1101;
  localparam int         PREAMBLE_LEN = 4;

endpackage

// File: rtl/tx_bit_counter.sv
// Down-counter tracking the remaining bits of the current frame section;
// loads a start index, steps down on each strobed bit and flags zero.
module tx_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/preamble_tx.sv
// Frame serializer: sends preamble 1101 then the payload MSB first on a
// registered line. Define PREAMBLE_TX_PARITY_EN to append an even-parity bit.
module preamble_tx
  import preamble_tx_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 shift_en,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CNT_MAX = (DATA_BITS > PREAMBLE_LEN) ? DATA_BITS : PREAMBLE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);
  // The first preamble bit goes straight to the line, so the remaining
  // preamble bits and the payload share one shift register.
  localparam int SR_W    = PREAMBLE_LEN - 1 + DATA_BITS;

  state_t           state;
  state_t           state_next;
  logic [SR_W-1:0]  sr;
  logic             accept;
  logic             shift_bit;
  logic             line_upd;
  logic             line_next;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
`ifdef PREAMBLE_TX_PARITY_EN
  logic             parity_q;
`endif

  tx_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_bit  = 1'b0;
    line_upd   = 1'b0;
    line_next  = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        // shift_en is deliberately ignored here so bit 0 gets a full period.
        line_upd = 1'b1;
        if (tx_start) begin
          accept     = 1'b1;
          state_next = ST_PREAMBLE;
          line_next  = PREAMBLE[PREAMBLE_LEN-1];
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(PREAMBLE_LEN - 1);
        end
      end
      ST_PREAMBLE: begin
        if (shift_en) begin
          line_upd  = 1'b1;
          line_next = sr[SR_W-1];
          shift_bit = 1'b1;
          if (cnt_zero) begin
            state_next = ST_PAYLOAD;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(DATA_BITS - 1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (shift_en) begin
          line_upd = 1'b1;
          if (cnt_zero) begin
`ifdef PREAMBLE_TX_PARITY_EN
            state_next = ST_PARITY;
            line_next  = parity_q;
`else
            state_next = ST_DONE;
            line_next  = 1'b0;
`endif
          end else begin
            line_next = sr[SR_W-1];
            shift_bit = 1'b1;
            cnt_dec   = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (shift_en) begin
          state_next = ST_DONE;
          line_upd   = 1'b1;
          line_next  = 1'b0;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        line_upd   = 1'b1;
        line_next  = 1'b0;
      end
      default: begin
        state_next = ST_IDLE;
        line_upd   = 1'b1;
        line_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr         <= '0;
      serial_out <= 1'b0;
    end else begin
      if (accept) begin
        sr <= {PREAMBLE[PREAMBLE_LEN-2:0], tx_data};
      end else if (shift_bit) begin
        sr <= {sr[SR_W-2:0], 1'b0};
      end
      if (line_upd) begin
        serial_out <= line_next;
      end
    end
  end

`ifdef PREAMBLE_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^tx_data;
    end
  end
`endif

  assign busy    = (state != ST_IDLE);
  assign tx_done = (state == ST_DONE);

endmodule
